// File: rtl/string_accel_mm.sv
// string_accel_mm: Avalon-MM slave string accelerator.
// Holds byte strings A and B plus a result string R and runs STRLEN, STRCMP,
// TOUPPER or FINDCHR over them at one character per clock. Completion is
// reported through STATUS.done and an optional level interrupt.
module string_accel_mm #(
    parameter int MAX_BLOCKS = 4,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int N  = 4 * MAX_BLOCKS;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = 8 * N;

    localparam logic [31:0] CTRL_ADDR = 32'd0;
    localparam logic [31:0] STAT_ADDR = 32'd1;
    localparam logic [31:0] RES_ADDR  = 32'd2;
    localparam logic [31:0] A_BASE    = 32'd4;
    localparam logic [31:0] B_BASE    = 32'(4 + MAX_BLOCKS);
    localparam logic [31:0] R_BASE    = 32'(4 + 2 * MAX_BLOCKS);

    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    localparam logic [2:0] OP_STRLEN  = 3'd0;
    localparam logic [2:0] OP_STRCMP  = 3'd1;
    localparam logic [2:0] OP_TOUPPER = 3'd2;
    localparam logic [2:0] OP_FINDCHR = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Lower-case ASCII test used by TOUPPER
    function automatic logic is_lower_f(input logic [7:0] c);
        return (c >= 8'h61) && (c <= 8'h7A);
    endfunction

    // TOUPPER character mapping
    function automatic logic [7:0] to_upper_f(input logic [7:0] c);
        return is_lower_f(c) ? (c - 8'h20) : c;
    endfunction

    state_t         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [2:0]     opcode_q, opcode_d;
    logic           irq_en_q, irq_en_d;
    logic [7:0]     key_q, key_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic           err_op_q, err_op_d;
    logic           err_busy_q, err_busy_d;
    logic [31:0]    result_q, result_d;
    logic [SW-1:0]  a_q, a_d;
    logic [SW-1:0]  b_q, b_d;
    logic [SW-1:0]  r_q, r_d;
    logic [31:0]    readdata_q, readdata_d;
    logic           irq_q, irq_d;

    logic [31:0]    addr32_s;
    logic [31:0]    rdata_s;
    logic [7:0]     a_ch_s;
    logic [7:0]     b_ch_s;
    logic           wr_s;
    logic           ctrl_wr_s;
    logic           go_s;
    logic           host_ok_s;
    logic           term_s;
    logic           unused_s;

    assign addr32_s = 32'(address);
    assign a_ch_s   = a_q[{k_q, 3'b000} +: 8];
    assign b_ch_s   = b_q[{k_q, 3'b000} +: 8];
    assign wr_s     = chipselect & write;
    assign ctrl_wr_s = wr_s && (addr32_s == CTRL_ADDR);
    assign go_s     = ctrl_wr_s && writedata[1];
    // DONE already holds the final result, so the host may reprogram and
    // restart there; that is how a go coinciding with done-set is accepted.
    assign host_ok_s = (state_q != RUN);
    assign unused_s = ^{writedata[31:16], writedata[7:6], writedata[0]};

    assign readdata = readdata_q;
    assign irq      = irq_q;

    // Register-map read multiplexer over the current register contents
    always_comb begin
        rdata_s = 32'd0;
        case (addr32_s)
            CTRL_ADDR: rdata_s = {16'd0, key_q, 2'd0, irq_en_q, opcode_q, 2'd0};
            STAT_ADDR: rdata_s = {28'd0, err_busy_q, err_op_q, busy_q, done_q};
            RES_ADDR:  rdata_s = result_q;
            default:   rdata_s = 32'd0;
        endcase
        for (int w = 0; w < MAX_BLOCKS; w++) begin
            rdata_s = (addr32_s == A_BASE + 32'(w)) ? a_q[32*w +: 32] : rdata_s;
            rdata_s = (addr32_s == B_BASE + 32'(w)) ? b_q[32*w +: 32] : rdata_s;
            rdata_s = (addr32_s == R_BASE + 32'(w)) ? r_q[32*w +: 32] : rdata_s;
        end
    end

    // Host writes, FSM next state, per-character operation step and go handling
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        opcode_d   = opcode_q;
        irq_en_d   = irq_en_q;
        key_d      = key_q;
        done_d     = done_q;
        busy_d     = busy_q;
        err_op_d   = err_op_q;
        err_busy_d = err_busy_q;
        result_d   = result_q;
        a_d        = a_q;
        b_d        = b_q;
        r_d        = r_q;
        term_s     = 1'b0;

        // CTRL fields and go-while-busy detection
        if (ctrl_wr_s && host_ok_s) begin
            opcode_d = writedata[4:2];
            irq_en_d = writedata[5];
            key_d    = writedata[15:8];
        end else if (go_s) begin
            err_busy_d = 1'b1;
        end else begin
            err_busy_d = err_busy_d;
        end

        // STATUS write-1-to-clear; a done-set later in this block wins
        if (wr_s && (addr32_s == STAT_ADDR)) begin
            done_d     = done_d & ~writedata[0];
            err_op_d   = err_op_d & ~writedata[2];
            err_busy_d = err_busy_d & ~writedata[3];
        end else begin
            done_d = done_d;
        end

        // String loads are dropped while an operation is running
        for (int w = 0; w < MAX_BLOCKS; w++) begin
            a_d[32*w +: 32] = (wr_s && host_ok_s && (addr32_s == A_BASE + 32'(w)))
                              ? writedata : a_d[32*w +: 32];
            b_d[32*w +: 32] = (wr_s && host_ok_s && (addr32_s == B_BASE + 32'(w)))
                              ? writedata : b_d[32*w +: 32];
        end

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            RUN: begin
                case (opcode_q)
                    OP_STRLEN: begin
                        if (a_ch_s == 8'h00) begin
                            result_d = 32'(k_q);
                            term_s   = 1'b1;
                        end else if (k_q == K_LAST) begin
                            result_d = 32'(N);
                            term_s   = 1'b1;
                        end else begin
                            term_s = 1'b0;
                        end
                    end
                    OP_STRCMP: begin
                        if (a_ch_s != b_ch_s) begin
                            result_d = (a_ch_s > b_ch_s) ? 32'd1 : 32'hFFFF_FFFF;
                            term_s   = 1'b1;
                        end else if ((a_ch_s == 8'h00) || (k_q == K_LAST)) begin
                            result_d = 32'd0;
                            term_s   = 1'b1;
                        end else begin
                            term_s = 1'b0;
                        end
                    end
                    OP_TOUPPER: begin
                        r_d[{k_q, 3'b000} +: 8] = to_upper_f(a_ch_s);
                        if (is_lower_f(a_ch_s)) begin
                            result_d = result_q + 32'd1;
                        end else begin
                            result_d = result_q;
                        end
                        term_s = (a_ch_s == 8'h00) || (k_q == K_LAST);
                    end
                    OP_FINDCHR: begin
                        if (a_ch_s == key_q) begin
                            result_d = 32'(k_q);
                            term_s   = 1'b1;
                        end else if ((a_ch_s == 8'h00) || (k_q == K_LAST)) begin
                            result_d = 32'hFFFF_FFFF;
                            term_s   = 1'b1;
                        end else begin
                            term_s = 1'b0;
                        end
                    end
                    default: begin
                        term_s = 1'b1;
                    end
                endcase
                if (term_s) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Accepted go: clears sticky status, then starts or flags a bad opcode
        if (go_s && host_ok_s) begin
            done_d     = 1'b0;
            err_op_d   = 1'b0;
            err_busy_d = 1'b0;
            if (writedata[4] == 1'b0) begin
                state_d  = RUN;
                busy_d   = 1'b1;
                k_d      = '0;
                result_d = 32'd0;
                if (writedata[4:2] == OP_TOUPPER) begin
                    r_d = '0;
                end else begin
                    r_d = r_d;
                end
            end else begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                err_op_d = 1'b1;
                done_d   = 1'b1;
            end
        end else begin
            state_d = state_d;
        end
    end

    // Read data capture (latency 1, held between reads) and interrupt level
    always_comb begin
        readdata_d = (chipselect && read) ? rdata_s : readdata_q;
        irq_d      = done_d & irq_en_d;
    end

    // State register with synchronous reset that aborts any operation
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            opcode_q   <= 3'd0;
            irq_en_q   <= 1'b0;
            key_q      <= 8'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_op_q   <= 1'b0;
            err_busy_q <= 1'b0;
            result_q   <= 32'd0;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            readdata_q <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            opcode_q   <= opcode_d;
            irq_en_q   <= irq_en_d;
            key_q      <= key_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            err_op_q   <= err_op_d;
            err_busy_q <= err_busy_d;
            result_q   <= result_d;
            a_q        <= a_d;
            b_q        <= b_d;
            r_q        <= r_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_string_accel_mm.sv
// Directed bench for string_accel_mm (MAX_BLOCKS=4, N=16, ADDR_W=5).
module tb_string_accel_mm;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [4:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] rv;

    string_accel_mm #(.MAX_BLOCKS(4), .ADDR_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk);
        #1;
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] s;
        logic        got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            bus_rd(5'd1, s);
            got = s[0];
        end
        check({tag, "_done_wait"}, {31'd0, got}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] ctrl, input logic [31:0] exp);
        logic [31:0] res;
        bus_wr(5'd0, ctrl);
        wait_done(tag);
        bus_rd(5'd2, res);
        check(tag, res, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = 5'd0; writedata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_rd(5'd0, rv);  check("rst_ctrl", rv, 32'd0);
        bus_rd(5'd1, rv);  check("rst_status", rv, 32'd0);
        bus_rd(5'd2, rv);  check("rst_result", rv, 32'd0);

        // STRLEN "Hello": done (seen through irq) exactly 7 cycles after go
        bus_wr(5'd4, 32'h6C6C6548);
        bus_wr(5'd5, 32'h0000006F);
        bus_wr(5'd0, 32'h00000022);
        repeat (6) @(posedge clk);
        #1;
        check("strlen_irq_cycle6", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        check("strlen_irq_cycle7", {31'd0, irq}, 32'd1);
        bus_rd(5'd1, rv);  check("strlen_status", rv, 32'h1);
        bus_rd(5'd2, rv);  check("strlen_result", rv, 32'd5);

        // STRCMP
        bus_wr(5'd5, 32'h0);
        bus_wr(5'd4, 32'h00636261);
        bus_wr(5'd8, 32'h00646261);
        run_op("strcmp_lt", 32'h06, 32'hFFFF_FFFF);
        check("strcmp_irq_dis", {31'd0, irq}, 32'd0);
        bus_wr(5'd4, 32'h00646261);
        bus_wr(5'd8, 32'h00636261);
        run_op("strcmp_gt", 32'h06, 32'd1);
        bus_wr(5'd4, 32'h00636261);
        run_op("strcmp_eq", 32'h06, 32'd0);

        // TOUPPER with interrupt
        bus_wr(5'd4, 32'h7A395A61);
        run_op("toupper_count", 32'h2A, 32'd2);
        bus_rd(5'd12, rv); check("toupper_r0", rv, 32'h5A395A41);
        bus_rd(5'd13, rv); check("toupper_r1", rv, 32'h0);
        check("toupper_irq", {31'd0, irq}, 32'd1);
        bus_wr(5'd1, 32'h1);
        check("w1c_irq", {31'd0, irq}, 32'd0);
        bus_rd(5'd1, rv);  check("w1c_status", rv, 32'h0);

        // FINDCHR on "hello"
        bus_wr(5'd4, 32'h6C6C6568);
        bus_wr(5'd5, 32'h0000006F);
        run_op("findchr_l", 32'h6C0E, 32'd2);
        run_op("findchr_miss", 32'h710E, 32'hFFFF_FFFF);
        bus_rd(5'd0, rv);  check("ctrl_readback", rv, 32'h0000710C);
        run_op("findchr_nul", 32'h000E, 32'd5);

        // STRLEN with no NUL
        for (int w = 4; w < 8; w++) bus_wr(5'(w), 32'h41414141);
        run_op("strlen_full", 32'h02, 32'd16);

        // go while busy is rejected and flagged
        bus_wr(5'd0, 32'h02);
        bus_wr(5'd0, 32'h0E);
        wait_done("busy_go");
        bus_rd(5'd2, rv);  check("busy_go_result", rv, 32'd16);
        bus_rd(5'd1, rv);  check("busy_go_status", rv, 32'h9);
        bus_rd(5'd0, rv);  check("busy_go_ctrl", rv, 32'h0);

        // invalid opcode
        bus_wr(5'd1, 32'hD);
        bus_wr(5'd0, 32'h16);
        bus_rd(5'd1, rv);  check("bad_op_status", rv, 32'h5);

        // reset in the middle of RUN
        bus_rd(5'd4, rv);  check("pre_reset_a0", rv, 32'h41414141);
        bus_wr(5'd0, 32'h22);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_rst_irq", {31'd0, irq}, 32'd0);
        check("midrun_rst_readdata", readdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        bus_rd(5'd1, rv);  check("midrun_rst_status", rv, 32'h0);
        bus_rd(5'd2, rv);  check("midrun_rst_result", rv, 32'h0);
        bus_rd(5'd0, rv);  check("midrun_rst_ctrl", rv, 32'h0);
        bus_rd(5'd4, rv);  check("midrun_rst_a0", rv, 32'h0);
        check("midrun_rst_irq_late", {31'd0, irq}, 32'd0);

        // read hold and unmapped read
        bus_wr(5'd4, 32'h12345678);
        bus_rd(5'd4, rv);  check("a0_readback", rv, 32'h12345678);
        repeat (3) @(posedge clk);
        #1;
        check("readdata_hold", readdata, 32'h12345678);
        bus_rd(5'd31, rv); check("unmapped_read", rv, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/string_accel_mm.md
Name:
string_accel_mm

Overview:
- Parametrised Avalon-MM slave string accelerator that replaces the fixed two-word string block on the Nios II bus.
- Holds two byte strings A and B of up to 4*MAX_BLOCKS chars, plus a result string.
- Runs one of four operations (STRLEN, STRCMP, TOUPPER, FINDCHR) at one char per clock via an FSM.
- Reports completion through a status register and an optional level interrupt.

Parameters:
- MAX_BLOCKS, 4: 32-bit words per string; N = 4*MAX_BLOCKS chars.
- ADDR_W, 5: word-address width. Must satisfy 4 + 3*MAX_BLOCKS <= 2**ADDR_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- chipselect  in  1  Avalon slave select
- read  in  1  read strobe
- write  in  1  write strobe
- address  in  ADDR_W  word address
- writedata  in  32  write data
- readdata  out  32  registered read data, fixed read latency 1
- irq  out  1  level interrupt = done & irq_en

Behaviour:
- Clocking and reset:
  - reset: reset, synchronous, active-high; clock: clk.
  - Reset clears all registers, strings, readdata and irq to 0; FSM goes to IDLE.
  - Reset mid-operation aborts the operation immediately; no done is produced.
- Char order: char i is word i/4, bits [8*(i%4)+7 : 8*(i%4)]. Chars are unsigned bytes.
- Register map:
  - 0 CTRL (R/W): bit1 go (write-only, reads 0); bits4:2 opcode; bit5 irq_en; bits15:8 key char.
  - 1 STATUS: bit0 done, bit1 busy, bit2 err_op, bit3 err_busy. Write-1-to-clear on bits 0, 2, 3.
  - 2 RESULT (RO).
  - 4 .. 3+MB: A.
  - 4+MB .. 3+2MB: B.
  - 4+2MB .. 3+3MB: R (RO).
  - Unmapped reads return 0; unmapped writes are ignored.
- Reads: readdata updates on the edge after a read with chipselect and holds until the next read.
- FSM states IDLE, RUN, DONE:
  - IDLE + go with a valid opcode: index k=0, RESULT=0. TOUPPER also clears R. busy=1 next cycle.
  - IDLE + go with an invalid opcode (4-7): err_op=1 and done=1 on the next edge; stay IDLE.
  - RUN examines char k each cycle.
  - Terminate when the char is NUL, the op condition is hit, or k=N-1.
  - On termination, the next edge sets busy=0, done=1 and passes through DONE for one cycle back to IDLE.
  - A string with its first char at k terminates k+2 cycles after the go write.
- Opcodes:
  - 0 STRLEN: RESULT = index of the first NUL in A, or N if there is none.
  - 1 STRCMP: compares A[k] and B[k] until they differ or A[k]=NUL. RESULT = 0 if equal, 1 if A>B, 0xFFFFFFFF if A<B. Comparison of the first differing char is unsigned.
  - 2 TOUPPER: R[k] = A[k] - 0x20 if 0x61..0x7A, else A[k]. The NUL is copied and remaining R chars stay 0. RESULT = count of chars converted.
  - 3 FINDCHR: RESULT = first k with A[k] == key. Returns 0xFFFFFFFF if NUL or the end is reached first. key=0x00 returns the STRLEN index.
- While busy:
  - CTRL, A and B writes are ignored.
  - A go write sets err_busy=1 and does not restart.
  - Reads are always served; R/RESULT may be partial while busy.
- Simultaneous events:
  - Done-set and a STATUS W1C of done in the same cycle: done stays 1.
  - A go write in the same cycle as done-set is accepted as a new operation; done clears on that go.
  - Any accepted go clears done, err_op and err_busy.

Test Plan:
- Write A="Hello\0" (word0 0x6C6C6548, word1 0x0000006F), CTRL go op0 -> RESULT=5 and done=1 on cycle 7 after the go write, busy=0.
- A="abc", B="abd", op1 -> RESULT=0xFFFFFFFF. Swap A and B -> 1. A=B="abc" -> 0.
- A="aZ9z" (0x7A395A61), op2, irq_en=1 -> R word0 = 0x5A395A41, RESULT=2, irq=1. W1C STATUS bit0 -> irq=0.
- A="hello", key 0x6C, op3 -> 2. key 0x71 -> 0xFFFFFFFF.
- A with all N chars non-NUL (0x41), op0 -> RESULT=N=16.
- Edge cases:
  - go during busy -> err_busy=1, RESULT unchanged.
  - opcode 5 -> err_op=1, done=1.
  - reset mid-RUN -> all registers 0, irq=0.
  - read address 31 -> readdata=0 one cycle later.
